// File: rtl/hdmi_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pll_supervisor
// Brief    : Sequences HDMI PLL reset, qualifies lock stability, retries on
//            timeout and latches a fault after the retry budget is spent.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [RST_W-1:0] c_RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] c_STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       c_MAX_RETRY = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PRST      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_lock_meta;
    logic               r_lock_s;
    logic               r_lock_lost;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [STB_W-1:0]   r_stb_cnt;
    logic [3:0]         r_retry;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_PRST;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
            r_stb_cnt   <= '0;
            r_retry     <= '0;
        end else begin
            r_lock_meta <= lock;
            r_lock_s    <= r_lock_meta;
            r_lock_lost <= 1'b0;
            if (restart) begin
                r_state   <= S_PRST;
                r_rst_cnt <= '0;
                r_to_cnt  <= '0;
                r_stb_cnt <= '0;
                r_retry   <= '0;
            end else begin
                case (r_state)
                    S_PRST: begin
                        if (r_rst_cnt == c_RST_LAST) begin
                            r_rst_cnt <= '0;
                            r_to_cnt  <= '0;
                            r_state   <= S_WAIT_LOCK;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        // Timeout counter saturates so an expired window is never missed.
                        if (r_to_cnt != c_TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_lock_s) begin
                            r_stb_cnt <= '0;
                            r_state   <= S_STABLE;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            if (r_retry < c_MAX_RETRY) begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_PRST;
                            end else begin
                                r_state <= S_FAULT;
                            end
                        end
                    end
                    S_STABLE: begin
                        if (r_to_cnt != c_TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_lock_s && (r_stb_cnt == c_STB_LAST)) begin
                            r_retry <= '0;
                            r_state <= S_READY;
                        end else if (!r_lock_s) begin
                            r_stb_cnt <= '0;
                            r_state   <= S_WAIT_LOCK;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            if (r_retry < c_MAX_RETRY) begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_PRST;
                            end else begin
                                r_state <= S_FAULT;
                            end
                        end else begin
                            r_stb_cnt <= r_stb_cnt + 1'b1;
                        end
                    end
                    S_READY: begin
                        if (!r_lock_s) begin
                            r_lock_lost <= 1'b1;
                            r_state     <= S_PRST;
                        end
                    end
                    S_FAULT: begin
                        r_state <= S_FAULT;
                    end
                    default: begin
                        r_state <= S_PRST;
                    end
                endcase
            end
        end
    end

    // Outputs decode straight from the state register so async reset shows at once.
    assign pll_reset   = (r_state == S_PRST) || (r_state == S_FAULT);
    assign ready       = (r_state == S_READY);
    assign fault       = (r_state == S_FAULT);
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_pll_supervisor
// Brief    : Self-checking bench for hdmi_pll_supervisor (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hdmi_pll_supervisor;

    localparam int RST  = 4;
    localparam int TO   = 64;
    localparam int STB  = 8;
    localparam int MAXR = 2;

    logic       clkin   = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock    = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset, ready, lock_lost, fault;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    hdmi_pll_supervisor #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(STB),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .lock       (lock),
        .restart    (restart),
        .pll_reset  (pll_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #5 clkin = ~clkin;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: phases of the supervisor described by elapsed time and lock runs.
    localparam int P_PULSE = 0, P_WAIT = 1, P_QUAL = 2, P_READY = 3, P_FAULT = 4;
    int m_phase, m_left, m_elapsed, m_run, m_retries;
    bit m_lost, m_s1, m_s2;

    task automatic model_reset();
        m_phase = P_PULSE; m_left = RST; m_elapsed = 0; m_run = 0;
        m_retries = 0; m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic give_up();
        if (m_retries < MAXR) begin
            m_retries++;
            m_phase = P_PULSE;
            m_left  = RST;
        end else begin
            m_phase = P_FAULT;
        end
    endtask

    task automatic model_step(input bit lk, input bit rs);
        bit ls;
        bit expired;
        ls = m_s2; m_s2 = m_s1; m_s1 = lk;
        m_lost = 1'b0;
        if (rs) begin
            m_phase = P_PULSE; m_left = RST; m_retries = 0; m_elapsed = 0; m_run = 0;
        end else begin
            expired = (m_elapsed >= TO - 1);
            case (m_phase)
                P_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_WAIT; m_elapsed = 0; end
                end
                P_WAIT: begin
                    m_elapsed++;
                    if (ls) begin m_phase = P_QUAL; m_run = 0; end
                    else if (expired) give_up();
                end
                P_QUAL: begin
                    m_elapsed++;
                    if (ls) m_run++;
                    if (ls && m_run == STB) begin m_phase = P_READY; m_retries = 0; end
                    else if (!ls) m_phase = P_WAIT;
                    else if (expired) give_up();
                end
                P_READY: begin
                    if (!ls) begin m_phase = P_PULSE; m_left = RST; m_lost = 1'b1; end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] r;
        r = 4'(m_retries);
        return {(m_phase == P_PULSE) || (m_phase == P_FAULT), m_phase == P_READY,
                m_lost, m_phase == P_FAULT, r};
    endfunction

    // One active edge; inputs are captured before it, outputs settle 2 ns after.
    task automatic tick();
        bit lk, rs;
        lk = lock; rs = restart;
        @(posedge clkin);
        model_step(lk, rs);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clkin);
        reset_n = 1'b0; lock = 1'b0; restart = 1'b0;
        model_reset();
        repeat (2) @(negedge clkin);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clkin);
        reset_n = 1'b0; lock = 1'b1; restart = 1'b0;
        model_reset();
        @(posedge clkin); #2;
        checks++;
        if ({pll_reset, ready, lock_lost, fault, retry_count} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_values: got %b want %b",
                     {pll_reset, ready, lock_lost, fault, retry_count}, 8'b1000_0000);
        end
    endtask

    task automatic test_lock_acquire();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            checks++;
            if (pll_reset !== (c < RST)) begin
                errors++;
                $display("FAIL prst_pulse c=%0d: got %b want %b", c, pll_reset, c < RST);
            end
        end
        lock = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (ready !== (10 + k >= 11 + STB + 2)) begin
                errors++;
                $display("FAIL lock_latency edge=%0d: got %b want %b", 10 + k, ready,
                         10 + k >= 11 + STB + 2);
            end
        end
        checks++;
        if (retry_count !== 4'd0) begin
            errors++;
            $display("FAIL acquire_retry: got %0d want 0", retry_count);
        end
    endtask

    task automatic test_lock_loss();
        bit el, ep, er;
        do_reset();
        lock = 1'b1;
        repeat (20) tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL loss_setup_ready: got %b want 1", ready);
        end
        lock = 1'b0;
        tick();
        lock = 1'b1;
        for (int d = 1; d <= 16; d++) begin
            tick();
            er = (d <= 1) || (d >= 15);
            ep = (d >= 2) && (d <= 5);
            el = (d == 2);
            checks++;
            if ({ready, pll_reset, lock_lost} !== {er, ep, el}) begin
                errors++;
                $display("FAIL lock_loss d=%0d: got rdy/prst/lost %b want %b", d,
                         {ready, pll_reset, lock_lost}, {er, ep, el});
            end
        end
    endtask

    task automatic test_stable_glitch();
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            lock = (e >= 5) && (e != 11);
            tick();
            checks++;
            if (ready !== (e >= 22)) begin
                errors++;
                $display("FAIL stable_glitch e=%0d: got %b want %b", e, ready, e >= 22);
            end
        end
        // Repeated glitches: the lock window must still expire on its original schedule.
        do_reset();
        for (int e = 1; e <= 68; e++) begin
            lock = (e >= 5) && !((e >= 11) && (e % 7 == 4));
            tick();
            checks++;
            if ({ready, retry_count} !== {1'b0, (e >= 68) ? 4'd1 : 4'd0}) begin
                errors++;
                $display("FAIL timeout_continues e=%0d: got rdy/retry %b/%0d want 0/%0d",
                         e, ready, retry_count, (e >= 68) ? 1 : 0);
            end
        end
        checks++;
        if (pll_reset !== 1'b1) begin
            errors++;
            $display("FAIL timeout_continues_prst: got %b want 1", pll_reset);
        end
    endtask

    task automatic test_timeout_fault();
        bit ep, ef;
        logic [3:0] erc;
        do_reset();
        for (int c = 0; c <= 210; c++) begin
            if (c > 0) tick();
            ef  = (c >= 204);
            ep  = (c < 4) || (c >= 68 && c < 72) || (c >= 136 && c < 140) || ef;
            erc = (c < 68) ? 4'd0 : (c < 136) ? 4'd1 : 4'd2;
            checks++;
            if ({pll_reset, fault, retry_count} !== {ep, ef, erc}) begin
                errors++;
                $display("FAIL timeout_fault c=%0d: got prst/fault/retry %b/%b/%0d want %b/%b/%0d",
                         c, pll_reset, fault, retry_count, ep, ef, erc);
            end
        end
    endtask

    task automatic test_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if ({fault, retry_count, pll_reset} !== {1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_from_fault: got fault/retry/prst %b/%0d/%b want 0/0/1",
                     fault, retry_count, pll_reset);
        end
        for (int d = 1; d <= 67; d++) begin
            tick();
            checks++;
            if ({pll_reset, retry_count} !== {(d < RST), 4'd0}) begin
                errors++;
                $display("FAIL restart_pulse d=%0d: got prst/retry %b/%0d want %b/0",
                         d, pll_reset, retry_count, d < RST);
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if ({pll_reset, fault, retry_count, lock_lost} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_at_timeout: got prst/fault/retry/lost %b/%b/%0d/%b want 1/0/0/0",
                     pll_reset, fault, retry_count, lock_lost);
        end
        for (int d = 69; d <= 72; d++) begin
            tick();
            checks++;
            if ({pll_reset, retry_count} !== {(d < 72), 4'd0}) begin
                errors++;
                $display("FAIL restart_at_timeout_pulse d=%0d: got prst/retry %b/%0d want %b/0",
                         d, pll_reset, retry_count, d < 72);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lock = 1'b1;
        repeat (20) tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL async_setup_ready: got %b want 1", ready);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pll_reset, ready, lock_lost, fault, retry_count} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL async_reset: got %b want %b",
                     {pll_reset, ready, lock_lost, fault, retry_count}, 8'b1000_0000);
        end
        model_reset();
        lock = 1'b0;
        @(negedge clkin);
        reset_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            checks++;
            if (pll_reset !== (c < RST)) begin
                errors++;
                $display("FAIL post_reset_pulse c=%0d: got %b want %b", c, pll_reset, c < RST);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        logic [7:0] exp;
        hold = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                lock = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            restart = ($urandom_range(0, 249) == 0);
            tick();
            exp = model_out();
            checks++;
            if ({pll_reset, ready, lock_lost, fault, retry_count} !== exp) begin
                errors++;
                $display("FAIL random i=%0d: got %b want %b", i,
                         {pll_reset, ready, lock_lost, fault, retry_count}, exp);
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_acquire();
        test_lock_loss();
        test_stable_glitch();
        test_timeout_fault();
        test_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
